// File: rtl/multiphase_gen_if.sv
// Control and phase-output bundle for the multiphase generator.
// master drives run controls, slave returns the phase outputs.
interface multiphase_gen_if #(
  parameter int NPH  = 4,
  parameter int DIVW = 4
);
  localparam int IW = (NPH > 1) ? $clog2(NPH) : 1;

  logic            en;
  logic [DIVW-1:0] div;
  logic            gap_en;
  logic            dir;
  logic [NPH-1:0]  ph;
  logic [IW-1:0]   phase_idx;
  logic            sync;
  logic            active;

  modport master (
    output en, div, gap_en, dir,
    input  ph, phase_idx, sync, active
  );

  modport slave (
    input  en, div, gap_en, dir,
    output ph, phase_idx, sync, active
  );
endinterface

// File: rtl/multiphase_gen.sv
// Non-overlapping multiphase clock generator.
// Rotates a one-hot phase with programmable hold and optional dead cycle.
module multiphase_gen #(
  parameter int NPH  = 4,
  parameter int DIVW = 4
) (
  input logic           clk,
  input logic           reset,
  multiphase_gen_if.slave bus
);
  localparam int IW = (NPH > 1) ? $clog2(NPH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [IW-1:0]  LAST = IW'(NPH - 1);
  localparam logic [NPH-1:0] ONE  = NPH'(1);

  logic [1:0]      state_q, state_d;
  logic [NPH-1:0]  ph_q, ph_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   nidx_q, nidx_d;
  logic            sync_q, sync_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [DIVW-1:0] dlat_q, dlat_d;

  logic [IW-1:0]   step_idx;
  logic [IW-1:0]   tgt_idx;
  logic            tc;

  assign tc = (cnt_q == dlat_q);

  // Neighbour phase with explicit wrap so non-power-of-2 NPH is correct.
  always_comb begin
    step_idx = idx_q;
    if (bus.dir) begin
      step_idx = (idx_q == '0) ? LAST : idx_q - 1'b1;
    end else begin
      step_idx = (idx_q == LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // GAP resumes at the neighbour chosen at terminal count.
  assign tgt_idx = (state_q == S_GAP) ? nidx_q : step_idx;

  // Next-state and phase-entry logic.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    idx_d   = idx_q;
    nidx_d  = nidx_q;
    sync_d  = 1'b0;
    cnt_d   = cnt_q;
    dlat_d  = dlat_q;
    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          state_d = S_DRIVE;
          idx_d   = '0;
          ph_d    = ONE;
          sync_d  = 1'b1;
          cnt_d   = '0;
          dlat_d  = bus.div;
        end
      end
      S_DRIVE, S_GAP: begin
        if (state_q == S_DRIVE && !tc) begin
          cnt_d = cnt_q + DIVW'(1);
        end else if (!bus.en) begin
          state_d = S_IDLE;
          ph_d    = '0;
          cnt_d   = '0;
        end else if (state_q == S_DRIVE && bus.gap_en) begin
          state_d = S_GAP;
          ph_d    = '0;
          nidx_d  = step_idx;
          cnt_d   = '0;
        end else begin
          state_d = S_DRIVE;
          idx_d   = tgt_idx;
          ph_d    = ONE << tgt_idx;
          sync_d  = (tgt_idx == '0);
          cnt_d   = '0;
          dlat_d  = bus.div;
        end
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      idx_q   <= '0;
      nidx_q  <= '0;
      sync_q  <= 1'b0;
      cnt_q   <= '0;
      dlat_q  <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      nidx_q  <= nidx_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      dlat_q  <= dlat_d;
    end
  end

  assign bus.ph        = ph_q;
  assign bus.phase_idx = idx_q;
  assign bus.sync      = sync_q;
  assign bus.active    = (state_q != S_IDLE);
endmodule

// File: doc/multiphase_gen.md
MULTIPHASE_GEN -- requirements
Module: multiphase_gen

Interface
REQ-001 SHALL have parameter NPH, default 4, number of non-overlapping phase outputs (legal range 2..16).
REQ-002 SHALL have parameter DIVW, default 4, width of the per-phase hold-count input.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (low = reset).
REQ-005 SHALL have port en  input  1  run request; high starts or continues phase rotation.
REQ-006 SHALL have port div  input  DIVW  hold count; each phase lasts div+1 clk cycles.
REQ-007 SHALL have port gap_en  input  1  when high, one dead cycle (all phases low) between phases.
REQ-008 SHALL have port dir  input  1  rotation direction: 0 ascending index, 1 descending index.
REQ-009 SHALL have port ph  output  NPH  phase outputs, one-hot or all-zero, registered.
REQ-010 SHALL have port phase_idx  output  $clog2(NPH)  index of current or last driven phase, registered.
REQ-011 SHALL have port sync  output  1  one-cycle pulse, registered, marking each entry into phase 0.
REQ-012 SHALL have port active  output  1  high whenever the block is not IDLE.

Function
REQ-013 SHALL implement a state machine with three states: IDLE, DRIVE, GAP.
REQ-014 IDLE: SHALL hold ph=0 and active=0; en=1 sampled at an edge SHALL move to DRIVE with phase_idx=0, ph[0]=1 and sync=1 from that edge (1-cycle latency).
REQ-015 DRIVE: SHALL hold ph one-hot at bit phase_idx; the internal hold counter counts 0..div_lat.
REQ-016 div SHALL be latched into div_lat on every phase entry; changes to div mid-phase SHALL take effect only at the next phase.
REQ-017 At terminal count (counter==div_lat) with en=1 and gap_en=0: SHALL advance directly to the next phase on the following cycle with no dead cycle.
REQ-018 At terminal count with en=1 and gap_en=1: SHALL enter GAP for exactly one cycle (ph=0, active=1, phase_idx unchanged), then DRIVE the next phase.
REQ-019 Next phase SHALL be (phase_idx+1) mod NPH for dir=0 and (phase_idx-1) mod NPH for dir=1; dir SHALL be sampled only at terminal count; wrap SHALL be correct for non-power-of-2 NPH (e.g. NPH=3: 2->0, 0->2).
REQ-020 gap_en SHALL be sampled only at terminal count.
REQ-021 en=0 mid-phase SHALL NOT truncate the phase; at terminal count with en=0 the block SHALL go to IDLE (ph=0, active=0) on the next cycle; en=0 in GAP SHALL go to IDLE on the next cycle.
REQ-022 sync SHALL be high exactly in the first cycle of every phase-0 entry (either direction) and low otherwise.
REQ-023 Re-entry from IDLE SHALL always restart at phase 0 regardless of prior phase_idx or dir.
REQ-024 div=0, gap_en=0, dir=0, NPH=4 SHALL produce a 4-cycle rotating one-hot sequence, one cycle per phase.
REQ-025 ph SHALL never have more than one bit set in any cycle.

Reset
REQ-026 reset low SHALL immediately, without a clock edge, force state=IDLE, ph=0, phase_idx=0, sync=0, active=0, hold counter=0, div_lat=0.
REQ-027 After reset returns high, the first en=1 edge SHALL start at phase 0 per REQ-014; reset mid-phase SHALL discard the phase.

Verification
REQ-028 NPH=4, div=0, gap_en=0, dir=0, en held 1 -> ph 0001,0010,0100,1000,0001...; sync high every 4th cycle aligned with 0001.
REQ-029 div=2 -> each phase 3 cycles; div changed to 0 in the 2nd cycle of phase 1 -> phase 1 still 3 cycles, phase 2 onward 1 cycle.
REQ-030 gap_en=1, div=0 -> ph 0001,0000,0010,0000,0100,0000,1000,0000,0001; active stays 1 throughout.
REQ-031 dir=1 from start -> 0001,1000,0100,0010; dir toggled mid-phase -> direction changes only at the next boundary; NPH=3 -> 001,100,010 descending.
REQ-032 div=3, en dropped in 2nd cycle of phase 1 -> phase 1 lasts 4 cycles total, then ph=0, active=0; en reasserted -> ph=0001 with sync=1 one cycle later.
REQ-033 reset driven low between clock edges during phase 2 -> ph=0, phase_idx=0, active=0 before the next edge; no output change while reset held low.
